// File: rtl/upd7800_cpgen.sv
// rtl/upd7800_cpgen.sv - uPD7800 CP1/CP2 four-step phase strobe generator
// Adds a clock divider, a clock enable, wait-state stretching and a debug pause.
module upd7800_cpgen #(
  parameter int DIV    = 1,
  parameter int WAIT_W = 4
) (
  input  logic              CLK,
  input  logic              RESETB,
  input  logic              CE,
  input  logic              PAUSE,
  input  logic              WAIT_REQ,
  input  logic [WAIT_W-1:0] WAIT_CNT,
  output logic              CP1_POSEDGE,
  output logic              CP1_NEGEDGE,
  output logic              CP2_POSEDGE,
  output logic              CP2_NEGEDGE,
  output logic              CP1,
  output logic              CP2,
  output logic              STALLED
);

  localparam int DW = $clog2(DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    S_START, S_P1H, S_P1L, S_WAIT, S_P2H, S_P2L, S_HALT
  } state_t;

  state_t            r_state, w_state_nx;
  logic [DW-1:0]     r_div, w_div_nx;
  logic [WAIT_W-1:0] r_wait, w_wait_nx;
  logic [WAIT_W-1:0] r_wlat, w_wlat_nx;
  logic [WAIT_W-1:0] w_wait_smp;
  logic [3:0]        r_strb, w_strb_nx;
  logic              w_step_end;

  // Wait request is captured in the cycle that shows CP1_NEGEDGE, even if CE is low then.
  assign w_wait_smp = r_strb[1] ? (WAIT_REQ ? WAIT_CNT : '0) : r_wlat;
  assign w_step_end = (r_div == DIV_LAST);

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_state <= S_START;
      r_div   <= '0;
      r_wait  <= '0;
      r_wlat  <= '0;
      r_strb  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_div   <= w_div_nx;
      r_wait  <= w_wait_nx;
      r_wlat  <= w_wlat_nx;
      r_strb  <= w_strb_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_div_nx   = r_div;
    w_wait_nx  = r_wait;
    w_wlat_nx  = w_wait_smp;
    w_strb_nx  = '0;
    if (CE) begin
      case (r_state)
        S_START: begin
          w_state_nx = S_P1H;
          w_div_nx   = '0;
          w_strb_nx  = 4'b0001;
        end
        S_HALT: begin
          if (!PAUSE) begin
            w_state_nx = S_P1H;
            w_div_nx   = '0;
            w_strb_nx  = 4'b0001;
          end
        end
        default: begin
          if (!w_step_end) begin
            w_div_nx = r_div + 1'b1;
          end else begin
            w_div_nx = '0;
            case (r_state)
              S_P1H: begin
                w_state_nx = S_P1L;
                w_strb_nx  = 4'b0010;
              end
              S_P1L: begin
                if (w_wait_smp != '0) begin
                  w_state_nx = S_WAIT;
                  w_wait_nx  = w_wait_smp;
                end else begin
                  w_state_nx = S_P2H;
                  w_strb_nx  = 4'b0100;
                end
              end
              S_WAIT: begin
                if (r_wait <= 1) begin
                  w_state_nx = S_P2H;
                  w_wait_nx  = '0;
                  w_strb_nx  = 4'b0100;
                end else begin
                  w_wait_nx = r_wait - 1'b1;
                end
              end
              S_P2H: begin
                w_state_nx = S_P2L;
                w_strb_nx  = 4'b1000;
              end
              S_P2L: begin
                if (PAUSE) begin
                  w_state_nx = S_HALT;
                end else begin
                  w_state_nx = S_P1H;
                  w_strb_nx  = 4'b0001;
                end
              end
              default: w_state_nx = S_START;
            endcase
          end
        end
      endcase
    end
  end

  assign CP1_POSEDGE = r_strb[0];
  assign CP1_NEGEDGE = r_strb[1];
  assign CP2_POSEDGE = r_strb[2];
  assign CP2_NEGEDGE = r_strb[3];
  assign CP1         = (r_state == S_P1H);
  assign CP2         = (r_state == S_P2H);
  assign STALLED     = (r_state == S_WAIT) || (r_state == S_HALT);

endmodule

// File: tb/tb_upd7800_cpgen.sv
// tb/tb_upd7800_cpgen.sv - directed vector bench for upd7800_cpgen (DIV=1 and DIV=3)
module tb_upd7800_cpgen;

  // Output word: {STALLED, CP2, CP1, CP2_NEG, CP2_POS, CP1_NEG, CP1_POS}
  localparam logic [6:0] O_P1H  = 7'b0010001;
  localparam logic [6:0] O_P1L  = 7'b0000010;
  localparam logic [6:0] O_P2H  = 7'b0100100;
  localparam logic [6:0] O_P2L  = 7'b0001000;
  localparam logic [6:0] O_STL  = 7'b1000000;
  localparam logic [6:0] O_ZERO = 7'b0000000;
  localparam logic [6:0] O_C1HD = 7'b0010000;
  localparam logic [6:0] O_C2HD = 7'b0100000;

  typedef struct {
    logic       ce;
    logic       pause;
    logic       wreq;
    logic [3:0] wcnt;
    logic [6:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       ce = 1'b0;
  logic       pause = 1'b0;
  logic       wreq = 1'b0;
  logic [3:0] wcnt = 4'd0;

  logic a_p1p, a_p1n, a_p2p, a_p2n, a_c1, a_c2, a_st;
  logic b_p1p, b_p1n, b_p2p, b_p2n, b_c1, b_c2, b_st;
  logic [6:0] d1_o, d3_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  upd7800_cpgen #(.DIV(1), .WAIT_W(4)) u_d1 (
    .CLK(clk), .RESETB(resetb), .CE(ce), .PAUSE(pause), .WAIT_REQ(wreq), .WAIT_CNT(wcnt),
    .CP1_POSEDGE(a_p1p), .CP1_NEGEDGE(a_p1n), .CP2_POSEDGE(a_p2p), .CP2_NEGEDGE(a_p2n),
    .CP1(a_c1), .CP2(a_c2), .STALLED(a_st)
  );

  upd7800_cpgen #(.DIV(3), .WAIT_W(4)) u_d3 (
    .CLK(clk), .RESETB(resetb), .CE(ce), .PAUSE(pause), .WAIT_REQ(wreq), .WAIT_CNT(wcnt),
    .CP1_POSEDGE(b_p1p), .CP1_NEGEDGE(b_p1n), .CP2_POSEDGE(b_p2p), .CP2_NEGEDGE(b_p2n),
    .CP1(b_c1), .CP2(b_c2), .STALLED(b_st)
  );

  assign d1_o = {a_st, a_c2, a_c1, a_p2n, a_p2p, a_p1n, a_p1p};
  assign d3_o = {b_st, b_c2, b_c1, b_p2n, b_p2p, b_p1n, b_p1p};

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic add(input logic c, input logic p, input logic r, input logic [3:0] n,
                     input logic [6:0] e);
    vec_t v;
    v.ce = c; v.pause = p; v.wreq = r; v.wcnt = n; v.exp = e;
    tv.push_back(v);
  endtask

  task automatic apply(input logic c, input logic p, input logic r, input logic [3:0] n);
    @(negedge clk);
    ce = c; pause = p; wreq = r; wcnt = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] e3;
    int ph;
    int c1_cnt;

    // Basic run, wait of 2, CE gaps
    add(1,0,0,0,O_P1H); add(1,0,0,0,O_P1L); add(1,0,0,0,O_P2H); add(1,0,0,0,O_P2L);
    add(1,0,0,0,O_P1H); add(1,0,0,0,O_P1L); add(1,0,1,2,O_STL); add(1,0,0,0,O_STL);
    add(1,0,0,0,O_P2H); add(1,0,0,0,O_P2L); add(1,0,0,0,O_P1H);
    add(0,0,0,0,O_C1HD); add(1,0,0,0,O_P1L); add(0,0,0,0,O_ZERO); add(1,0,0,0,O_P2H);
    add(0,0,0,0,O_C2HD); add(1,0,0,0,O_P2L); add(0,0,0,0,O_ZERO); add(1,0,0,0,O_P1H);
    // Pause raised mid-cycle, then released
    add(1,1,0,0,O_P1L); add(1,1,0,0,O_P2H); add(1,1,0,0,O_P2L); add(1,1,0,0,O_STL);
    add(1,1,0,0,O_STL); add(0,0,0,0,O_STL); add(1,0,0,0,O_P1H);
    // Pause combined with a wait of 1
    add(1,1,0,0,O_P1L); add(1,1,1,1,O_STL); add(1,1,0,0,O_P2H); add(1,1,0,0,O_P2L);
    add(1,1,0,0,O_STL); add(1,0,0,0,O_P1H);
    // Wait sampled while CE is low, then WAIT_CNT=0 means no wait
    add(1,0,0,0,O_P1L); add(0,0,1,1,O_ZERO); add(1,0,0,0,O_STL); add(1,0,0,0,O_P2H);
    add(1,0,0,0,O_P2L); add(1,0,0,0,O_P1H); add(1,0,0,0,O_P1L); add(1,0,1,0,O_P2H);
    add(1,0,0,0,O_P2L);

    repeat (3) @(posedge clk);
    #1;
    check("reset_d1", d1_o, O_ZERO);
    check("reset_d3", d3_o, O_ZERO);
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk);
    #1;
    check("start_hold_ce0", d1_o, O_ZERO);

    foreach (tv[i]) begin
      apply(tv[i].ce, tv[i].pause, tv[i].wreq, tv[i].wcnt);
      check($sformatf("vec%0d", i), d1_o, tv[i].exp);
    end

    // DIV=3: each step three cycles, period 12
    @(negedge clk);
    resetb = 1'b0; ce = 1'b0; pause = 1'b0; wreq = 1'b0; wcnt = 4'd0;
    @(negedge clk);
    check("reset2_d3", d3_o, O_ZERO);
    resetb = 1'b1; ce = 1'b1;
    c1_cnt = 0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk);
      #1;
      ph = ((c - 1) / 3) % 4;
      e3 = '0;
      e3[5] = (ph == 2);
      e3[4] = (ph == 0);
      if ((c - 1) % 3 == 0) e3[ph] = 1'b1;
      check($sformatf("div3_c%0d", c), d3_o, e3);
      if (c <= 12 && b_c1) c1_cnt++;
    end
    n_tests++;
    if (c1_cnt != 3) begin
      n_fail++;
      $display("FAIL div3_cp1_width got=%0d exp=3", c1_cnt);
    end

    // Asynchronous reset while in a 5-step wait
    @(negedge clk);
    resetb = 1'b0; ce = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    apply(1,0,0,0); check("rw_p1h", d1_o, O_P1H);
    apply(1,0,0,0); check("rw_p1l", d1_o, O_P1L);
    apply(1,0,1,5); check("rw_wait1", d1_o, O_STL);
    apply(1,0,0,0); check("rw_wait2", d1_o, O_STL);
    #2;
    resetb = 1'b0;
    #1;
    check("rw_async_zero", d1_o, O_ZERO);
    @(posedge clk);
    #1;
    check("rw_held_zero", d1_o, O_ZERO);
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk);
    #1;
    check("rw_restart_p1h", d1_o, O_P1H);
    apply(1,0,0,0); check("rw_restart_p1l", d1_o, O_P1L);
    apply(1,0,0,0); check("rw_restart_p2h", d1_o, O_P2H);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
